// File: rtl/char_incr.sv
// Address sequencer that walks curr_addr through the inclusive window [start_addr, end_addr],
// wrapping back to start_addr with a one-cycle overflow pulse on each wrap.
module char_incr #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] curr_addr,
  output logic                  overflow
);

  logic [ADDR_WIDTH-1:0] r_curr;
  logic                  r_ovf;

  logic                  w_degen;
  logic                  w_out_of_win;
  logic                  w_at_end;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_next_ovf;

  assign w_degen      = (start_addr > end_addr);
  assign w_out_of_win = (r_curr < start_addr) || (r_curr > end_addr);
  assign w_at_end     = (r_curr == end_addr);

  // Priority: degenerate window, then reload, then wrap, then increment.
  // The increment only happens below end_addr, so it can never carry out of W bits.
  always_comb begin
    w_next_addr = r_curr + 1'b1;
    w_next_ovf  = 1'b0;
    if (w_degen || w_out_of_win) begin
      w_next_addr = start_addr;
    end else if (w_at_end) begin
      w_next_addr = start_addr;
      w_next_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_curr <= w_next_addr;
      r_ovf  <= w_next_ovf;
    end
  end

  assign curr_addr = r_curr;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_char_incr.sv
// Self-checking bench for char_incr: directed scenarios with arithmetic expectations plus
// randomized windows checked against a behavioural model of the window-walk rules.
module tb_char_incr;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] start_addr = '0;
  logic [W-1:0] end_addr = '0;
  logic [W-1:0] curr_addr;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  int m_curr = 0;
  int m_ovf  = 0;

  char_incr #(.ADDR_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .curr_addr (curr_addr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model predicts from the inputs and address seen at the edge.
  task automatic adv();
    int s, e, nc, no;
    s = int'(start_addr);
    e = int'(end_addr);
    if (s > e)                        begin nc = s;          no = 0; end
    else if (m_curr < s || m_curr > e) begin nc = s;          no = 0; end
    else if (m_curr == e)             begin nc = s;          no = 1; end
    else                              begin nc = m_curr + 1; no = 0; end
    @(posedge clk);
    if (rst_n) begin m_curr = nc; m_ovf = no; end
    else       begin m_curr = 0;  m_ovf = 0;  end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_addr = 4'h0;
    end_addr = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (curr_addr !== 4'h0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: curr=%h ovf=%b, expected curr=0 ovf=0", curr_addr, overflow);
    end
    m_curr = 0; m_ovf = 0;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_full_range();
    for (int k = 1; k <= 20; k++) begin
      adv();
      n_cmp++;
      if (curr_addr !== W'(k % 16) || overflow !== ((k % 16) == 0)) begin
        n_err++;
        $display("FAIL full_range[%0d]: curr=%h ovf=%b, expected curr=%h ovf=%b",
                 k, curr_addr, overflow, k % 16, (k % 16) == 0);
      end
    end
  endtask

  task automatic test_window_change();
    logic [W-1:0] exp_a [5] = '{4'hE, 4'hF, 4'hE, 4'hF, 4'hE};
    logic         exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    adv();
    n_cmp++;
    if (curr_addr !== 4'h5) begin
      n_err++;
      $display("FAIL pre_change: curr=%h, expected 5", curr_addr);
    end
    start_addr = 4'hE;
    end_addr = 4'hF;
    for (int k = 0; k < 5; k++) begin
      adv();
      n_cmp++;
      if (curr_addr !== exp_a[k] || overflow !== exp_o[k]) begin
        n_err++;
        $display("FAIL win_change[%0d]: curr=%h ovf=%b, expected curr=%h ovf=%b",
                 k, curr_addr, overflow, exp_a[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_single_addr();
    int guard = 0;
    while (curr_addr !== 4'hF && guard < 4) begin adv(); guard++; end
    n_cmp++;
    if (curr_addr !== 4'hF) begin
      n_err++;
      $display("FAIL single_setup: curr=%h, expected F", curr_addr);
    end
    start_addr = 4'h8;
    end_addr = 4'h8;
    for (int k = 0; k < 4; k++) begin
      adv();
      n_cmp++;
      if (curr_addr !== 4'h8 || overflow !== (k != 0)) begin
        n_err++;
        $display("FAIL single[%0d]: curr=%h ovf=%b, expected curr=8 ovf=%b",
                 k, curr_addr, overflow, k != 0);
      end
    end
  endtask

  task automatic test_degenerate();
    start_addr = 4'hA;
    end_addr = 4'h3;
    for (int k = 0; k < 5; k++) begin
      adv();
      n_cmp++;
      if (curr_addr !== 4'hA || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL degenerate[%0d]: curr=%h ovf=%b, expected curr=A ovf=0",
                 k, curr_addr, overflow);
      end
    end
  endtask

  task automatic test_async_reset();
    start_addr = 4'h0;
    end_addr = 4'hF;
    repeat (3) adv();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (curr_addr !== 4'h0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: curr=%h ovf=%b, expected curr=0 ovf=0", curr_addr, overflow);
    end
    m_curr = 0; m_ovf = 0;
    start_addr = 4'h2;
    end_addr = 4'h9;
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    n_cmp++;
    if (curr_addr !== 4'h2 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: curr=%h ovf=%b, expected curr=2 ovf=0", curr_addr, overflow);
    end
  endtask

  task automatic test_window_3_6();
    int n_ovf = 0;
    start_addr = 4'h3;
    end_addr = 4'h6;
    adv();
    n_cmp++;
    if (curr_addr !== 4'h3 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL w36_entry: curr=%h ovf=%b, expected curr=3 ovf=0", curr_addr, overflow);
    end
    for (int k = 1; k <= 12; k++) begin
      adv();
      if (overflow) n_ovf++;
      n_cmp++;
      if (curr_addr !== W'(3 + (k % 4)) || overflow !== ((k % 4) == 0)) begin
        n_err++;
        $display("FAIL w36[%0d]: curr=%h ovf=%b, expected curr=%h ovf=%b",
                 k, curr_addr, overflow, 3 + (k % 4), (k % 4) == 0);
      end
    end
    n_cmp++;
    if (n_ovf != 3) begin
      n_err++;
      $display("FAIL w36_ovf_count: got %0d, expected 3", n_ovf);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        start_addr = W'($urandom_range(0, 15));
        end_addr   = W'($urandom_range(0, 15));
      end else if ($urandom_range(0, 29) == 0) begin
        end_addr = start_addr;
      end
      adv();
      n_cmp++;
      if (int'(curr_addr) != m_curr || int'(overflow) != m_ovf) begin
        n_err++;
        $display("FAIL random[%0d]: curr=%h ovf=%b, expected curr=%h ovf=%0d (win %h..%h)",
                 k, curr_addr, overflow, m_curr, m_ovf, start_addr, end_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_range();
    test_window_change();
    test_single_addr();
    test_degenerate();
    test_async_reset();
    test_window_3_6();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
